if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage of the multicycle RISC-V core, directly upstream of the control unit. Owns the program counter and the instruction register, runs a request/acknowledge handshake with a variable-latency instruction memory, and presents the fetched `opcode` that the control unit decodes. The control unit tells this block when to fetch and when to advance the PC, sequential or taken branch/jump.

## Interface
Parameters:
- `WIDTH`, 64: PC and address width.
- `RESET_PC`, 0: PC value after reset.
- `TIMEOUT`, 15: maximum wait cycles for `imem_ack` before a fetch error is flagged; range 1..255.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-high reset. The name is fixed by the codebase; the port is active-high.
- `fetch_req`  in  1  control unit requests a fetch; sampled only in IDLE.
- `pc_update`  in  1  control unit commits the next PC.
- `pc_src`  in  1  1 selects `branch_target`, 0 selects PC+4.
- `branch_target`  in  WIDTH  jump/branch target from the datapath.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  WIDTH  fetch address, equal to `pc`.
- `imem_ack`  in  1  memory response valid.
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`=1.
- `pc`  out  WIDTH  current PC register.
- `ir`  out  32  instruction register.
- `opcode`  out  7  `ir[6:0]`, feeds the control unit.
- `ir_valid`  out  1  one-cycle pulse when `ir` has just been loaded.
- `busy`  out  1  high while in REQ.
- `misalign`  out  1  sticky flag: a target with `[1:0]`≠0 was rejected.
- `fetch_err`  out  1  sticky flag: memory timeout.

## Operation
- States:
  - IDLE to REQ when `fetch_req`=1, `misalign`=0 and `fetch_err`=0. Otherwise `fetch_req` is ignored.
  - REQ to IDLE on `imem_ack`=1. `ir` is loaded from `imem_rdata` and `ir_valid` pulses.
  - REQ to IDLE when the wait counter reaches `TIMEOUT` without an ack. `fetch_err` is set and `ir` is unchanged.
- In REQ:
  - `imem_req`=1.
  - `imem_addr` is held stable until the ack.
  - The wait counter increments every cycle. It clears on entering REQ.
- PC update when `pc_update`=1 in IDLE:
  - `pc_src`=0: `pc` becomes `pc+4`, wrapping modulo 2^WIDTH.
  - `pc_src`=1 with `branch_target[1:0]`=0: `pc` becomes `branch_target`.
  - `pc_src`=1 with `branch_target[1:0]`≠0: `pc` is unchanged and `misalign` is set.
- PC update when `pc_update`=1 in REQ:
  - The update (`pc_src` and `branch_target`) is latched as pending.
  - It is applied on the edge that leaves REQ, after the address use is complete.
  - A second `pc_update` while one is already pending overwrites it (last wins).
- `fetch_req` and `pc_update` in the same IDLE cycle: the PC updates on that edge, and REQ issues the new PC.
- An ack arriving in IDLE (spurious) is ignored.
- `misalign` and `fetch_err` clear only on reset.

## Timing
- Reset values:
  - `pc`=`RESET_PC`.
  - `ir`=32'h00000013 (NOP), so `opcode`=7'b0010011.
  - `ir_valid`=0, `imem_req`=0, `busy`=0, `misalign`=0, `fetch_err`=0.
  - State is IDLE, counter is 0, no update pending.
- Asserting reset mid-REQ drops `imem_req` immediately (asynchronous) and discards any pending update.
- `fetch_req` sampled at edge N: `imem_req` is high from cycle N+1.
- Ack sampled at edge M: `ir` and `opcode` are valid and `ir_valid`=1 in cycle M+1, and `imem_req`=0 in cycle M+1.
- With a zero-wait memory (ack in the first REQ cycle), `ir_valid` follows `fetch_req` by 2 cycles.
- Timeout: with no ack, `fetch_err` rises `TIMEOUT` cycles after REQ entry, and `imem_req` drops in the same cycle.
- `opcode` is registered with `ir` and has no combinational path from `imem_rdata`.

## Test plan
- Reset then `fetch_req` with an ack one cycle later returning 32'h00500093 -> `imem_addr`=0, `ir`=32'h00500093, `opcode`=7'b0010011, and a single-cycle `ir_valid`.
- `pc_update`=1, `pc_src`=0 three times from PC 0 -> `pc`=12. Also with `pc`=2^WIDTH−4 -> `pc` wraps to 0.
- `pc_src`=1 with `branch_target`=0x40 -> `pc`=0x40. Then target 0x42 -> `pc` stays 0x40, `misalign`=1, and later `fetch_req` is ignored (`imem_req` stays 0).
- Memory holds ack for 5 cycles while `pc_update` (`pc_src`=1, target 0x80) arrives in REQ -> `imem_addr` stays at the old PC throughout REQ, and `pc`=0x80 in the cycle after the ack.
- No ack with `TIMEOUT`=15 -> `fetch_err`=1 exactly 15 cycles after REQ entry, `imem_req` drops, and `ir` is unchanged.
- Reset asserted mid-REQ -> `imem_req`=0 asynchronously and `pc`=`RESET_PC`. A following fetch works normally.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns PC and IR, runs a req/ack handshake with a
// variable-latency instruction memory and presents the decoded opcode field.
module if_fetch #(
    parameter int                 WIDTH    = 64,
    parameter logic [WIDTH-1:0]   RESET_PC = '0,
    parameter int                 TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_req,
    input  logic             pc_update,
    input  logic             pc_src,
    input  logic [WIDTH-1:0] branch_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [WIDTH-1:0] pc,
    output logic [31:0]      ir,
    output logic [6:0]       opcode,
    output logic             ir_valid,
    output logic             busy,
    output logic             misalign,
    output logic             fetch_err
);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [7:0]  LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic             irValid_q, irValid_d;
    logic             misalign_q, misalign_d;
    logic             fetchErr_q, fetchErr_d;
    logic             pending_q, pending_d;
    logic             pendSrc_q, pendSrc_d;
    logic [WIDTH-1:0] pendTarget_q, pendTarget_d;

    logic             applyUpd;
    logic             updSrc;
    logic [WIDTH-1:0] updTarget;
    logic             leaveReq;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pc_q         <= RESET_PC;
            ir_q         <= NOP;
            irValid_q    <= 1'b0;
            misalign_q   <= 1'b0;
            fetchErr_q   <= 1'b0;
            pending_q    <= 1'b0;
            pendSrc_q    <= 1'b0;
            pendTarget_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            irValid_q    <= irValid_d;
            misalign_q   <= misalign_d;
            fetchErr_q   <= fetchErr_d;
            pending_q    <= pending_d;
            pendSrc_q    <= pendSrc_d;
            pendTarget_q <= pendTarget_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        irValid_d    = 1'b0;
        misalign_d   = misalign_q;
        fetchErr_d   = fetchErr_q;
        pending_d    = pending_q;
        pendSrc_d    = pendSrc_q;
        pendTarget_d = pendTarget_q;
        applyUpd     = 1'b0;
        updSrc       = pc_src;
        updTarget    = branch_target;
        leaveReq     = 1'b0;

        case (state_q)
            IDLE: begin
                applyUpd = pc_update;
                if (fetch_req && !misalign_q && !fetchErr_q) begin
                    state_d = REQ;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (pc_update) begin
                    pending_d    = 1'b1;
                    pendSrc_d    = pc_src;
                    pendTarget_d = branch_target;
                end
                leaveReq = imem_ack || (cnt_q == LAST);
                // PC changes only on the leaving edge so the address stays stable;
                // an update arriving on that very edge wins over an older pending one.
                if (leaveReq) begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                    applyUpd  = pc_update || pending_q;
                    updSrc    = pc_update ? pc_src : pendSrc_q;
                    updTarget = pc_update ? branch_target : pendTarget_q;
                    if (imem_ack) begin
                        ir_d      = imem_rdata;
                        irValid_d = 1'b1;
                    end else begin
                        fetchErr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (applyUpd) begin
            if (!updSrc) begin
                pc_d = pc_q + WIDTH'(4);
            end else if (updTarget[1:0] == 2'b00) begin
                pc_d = updTarget;
            end else begin
                misalign_d = 1'b1;
            end
        end
    end

    assign imem_req  = (state_q == REQ);
    assign busy      = (state_q == REQ);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign opcode    = ir_q[6:0];
    assign ir_valid  = irValid_q;
    assign misalign  = misalign_q;
    assign fetch_err = fetchErr_q;

endmodule
